fifo_rr_arbiter: RTL and testbench
==================================

# fifo_rr_arbiter

Round-robin arbiter that shares one buffering FIFO between `NREQ` requesters (e.g. uncached-store, writeback and prefetch paths in memory management) and drains it to a single valid/ready consumer. Each entry is tagged with its requester ID. A per-requester occupancy limit stops one source from monopolising the buffer. The block sits between the requesters and the bus-side interface.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 32: payload width.
- `DEPTH`, 8: shared FIFO depth, ≥2.
- `MAX_PER_REQ`, 4: maximum entries one requester may hold, 1..DEPTH.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `flush_i`  in  1  discard all buffered entries.
- `req_i`  in  NREQ  per-requester push request; held until granted.
- `data_i`  in  NREQ×DATA_WIDTH  per-requester payload, packed, requester i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `gnt_o`  out  NREQ  one-hot or zero; entry accepted this cycle.
- `out_valid_o`  out  1  head entry available.
- `out_ready_i`  in  1  consumer takes head this cycle.
- `out_data_o`  out  DATA_WIDTH  head payload.
- `out_id_o`  out  $clog2(NREQ)  head requester ID.
- `full_o`  out  1  shared FIFO full.
- `usage_o`  out  $clog2(DEPTH)+1  entries held, 0..DEPTH.

## Operation
- Eligible(i) = `req_i[i]` & (cnt[i] < MAX_PER_REQ) & ~`full_o` & ~`flush_i`.
- Grant: first eligible index scanning from `rr_q` upward, wrapping modulo NREQ. At most one grant per cycle.
- On grant to i: push {i, data_i[i]} into the FIFO. `rr_q` ← (i+1) mod NREQ; wraps NREQ-1 → 0. With no grant, `rr_q` holds.
- Pop: `out_valid_o` & `out_ready_i`. Head leaves; cnt[out_id_o] decrements.
- cnt[i]: +1 on grant to i, −1 on pop of ID i. Both in the same cycle: unchanged. Width $clog2(MAX_PER_REQ+1). Never exceeds MAX_PER_REQ or drops below 0.
- Full FIFO: no grant, even if a pop occurs in the same cycle. Full is evaluated on registered occupancy.
- Empty FIFO: `out_valid_o`=0. No fall-through, so a pushed entry is never visible in its push cycle.
- Flush: the FIFO, all cnt[i] and `rr_q` clear to 0 at the next edge. During the flush cycle `gnt_o`=0, `out_valid_o`=0 and `out_ready_i` is ignored.
- Reset: all outputs and state are 0 the cycle after `rst_i` is sampled high: `gnt_o`=0, `out_valid_o`=0, `full_o`=0, `usage_o`=0, `rr_q`=0, cnt=0. Reset overrides flush. Reset mid-stream drops all entries without a pop handshake.
- `out_data_o` and `out_id_o` are don't-care while `out_valid_o`=0.

## Timing
- `gnt_o` is combinational from `req_i`, registered cnt and `rr_q`, registered `full_o` and `flush_i`. There is no path from `out_ready_i` to `gnt_o`.
- Push-to-output latency: an entry granted in cycle t is visible at `out_valid_o` in cycle t+1 at the earliest, when the FIFO was empty.
- Throughput: one grant and one pop per cycle simultaneously. `usage_o` is then unchanged.
- `usage_o` and `full_o` update one cycle after the grant or pop.
- Requesters sample `gnt_o` in the same cycle. Each must present a new `data_i`/`req_i` in the next cycle or deassert.

## Structure
- Package `fifo_arb_pkg` holds:
  - the entry struct typedef {id, data}, parameterised through localparam widths in the top;
  - the `NREQ` and `MAX_PER_REQ` legality checks as functions.
- Sub-module `rr_arbiter`: combinational priority scan of NREQ eligibles from a pointer, returning a one-hot grant and a valid flag. The top keeps `rr_q` and the cnt array.
- Storage is the codebase FIFO `fifo_v3_old` with FALL_THROUGH=0, DEPTH=`DEPTH`, dtype = the entry struct:
  - `push_i` = |`gnt_o`; `pop_i` = `out_valid_o` & `out_ready_i`;
  - `flush_i` is passed through and `testmode_i` is tied to 0;
  - `usage_o` is derived as FIFO count with an explicit full term, so DEPTH (a power of two) is reported correctly.
- Assertions:
  - `gnt_o` is one-hot or zero;
  - no grant while `full_o`;
  - cnt[i] ≤ MAX_PER_REQ;
  - Σcnt = `usage_o`.

## Test plan
- Round robin (NREQ=4, DEPTH=8, `out_ready_i`=1, all `req_i` high from reset) → grants in order 0,1,2,3,0; data out in the same order with IDs 0,1,2,3 one cycle after each grant.
- Per-requester cap (MAX_PER_REQ=2, only req 2 high, `out_ready_i`=0) → exactly two grants; `req_i[2]` then stays ungranted; `usage_o`=2; one pop yields exactly one further grant.
- Full with simultaneous pop (MAX=DEPTH=8, fill to 8, then `req_i`[0]=1 with `out_ready_i`=1) → no grant that cycle, grant the next cycle; `usage_o` goes 8→7→8.
- Wrap (`rr_q`=3 after grant to 3, `req_i`=4'b1001) → next grant to 0, then 3.
- Flush mid-stream (5 entries, assert `flush_i` with `req_i` and `out_ready_i` high) → `gnt_o`=0 and `out_valid_o`=0 in that cycle; next cycle `usage_o`=0 and all cnt=0; the first subsequent grant starts scanning at 0.
- Reset mid-operation (`rst_i` pulsed with 3 entries held) → the following cycle all outputs are 0 and a subsequent push is output with its own ID and data only.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO round-robin arbiter.
// Parameter legality checks, evaluated at elaboration by the top.
package fifo_arb_pkg;

    function automatic bit nreq_legal(input int unsigned nreq);
        return (nreq >= 2) && (nreq <= 16);
    endfunction

    function automatic bit depth_legal(input int unsigned depth);
        return depth >= 2;
    endfunction

    function automatic bit max_per_req_legal(input int unsigned max_per_req, input int unsigned depth);
        return (max_per_req >= 1) && (max_per_req <= depth);
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// Requester push bus and consumer valid/ready bus of the FIFO arbiter.
interface fifo_rr_arbiter_if #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned ID_W = $clog2(NREQ);

    logic [NREQ-1:0]            req_i;
    logic [NREQ*DATA_WIDTH-1:0] data_i;
    logic [NREQ-1:0]            gnt_o;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic [DATA_WIDTH-1:0]      out_data_o;
    logic [ID_W-1:0]            out_id_o;

    modport slave (
        input  req_i, data_i, out_ready_i,
        output gnt_o, out_valid_o, out_data_o, out_id_o
    );

    modport master (
        output req_i, data_i, out_ready_i,
        input  gnt_o, out_valid_o, out_data_o, out_id_o
    );
endinterface

// File: rtl/fifo_v3_old.sv
// Codebase FIFO with optional fall-through, flush and occupancy count.
module fifo_v3_old #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);
    localparam int unsigned FIFO_DEPTH = (DEPTH > 0) ? DEPTH : 1;

    logic [ADDR_DEPTH-1:0] read_pointer_q, write_pointer_q;
    logic [ADDR_DEPTH:0]   status_cnt_q;
    logic                  bypass, do_push, do_pop;
    logic                  unused_testmode;
    dtype                  mem_q [FIFO_DEPTH];

    assign unused_testmode = testmode_i;
    assign usage_o = status_cnt_q[ADDR_DEPTH-1:0];
    assign full_o  = (status_cnt_q == (ADDR_DEPTH+1)'(FIFO_DEPTH));
    assign empty_o = (status_cnt_q == '0) && !(FALL_THROUGH && push_i);
    assign data_o  = (FALL_THROUGH && status_cnt_q == '0) ? data_i : mem_q[read_pointer_q];

    // In fall-through mode a push and pop on an empty FIFO pass straight through.
    assign bypass  = FALL_THROUGH && (status_cnt_q == '0) && push_i && pop_i;
    assign do_push = push_i && !full_o && !bypass;
    assign do_pop  = pop_i && !empty_o && !bypass;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            read_pointer_q  <= '0;
            write_pointer_q <= '0;
            status_cnt_q    <= '0;
        end else if (flush_i) begin
            read_pointer_q  <= '0;
            write_pointer_q <= '0;
            status_cnt_q    <= '0;
        end else begin
            if (do_push)
                write_pointer_q <= (write_pointer_q == ADDR_DEPTH'(FIFO_DEPTH-1)) ? '0 : write_pointer_q + 1'b1;
            if (do_pop)
                read_pointer_q <= (read_pointer_q == ADDR_DEPTH'(FIFO_DEPTH-1)) ? '0 : read_pointer_q + 1'b1;
            if (do_push && !do_pop)
                status_cnt_q <= status_cnt_q + 1'b1;
            else if (do_pop && !do_push)
                status_cnt_q <= status_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push)
            mem_q[write_pointer_q] <= data_i;
    end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin scan: first eligible index at or above ptr,
// wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic             valid
);
    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % int'(NREQ));
            if (!found && eligible[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid = found;
endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one tagged FIFO between NREQ requesters,
// with a per-requester occupancy cap, draining to a valid/ready consumer.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned MAX_PER_REQ = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    fifo_rr_arbiter_if.slave        bus,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  usage_o
);
    localparam int unsigned ID_W    = $clog2(NREQ);
    localparam int unsigned CNT_W   = $clog2(MAX_PER_REQ + 1);
    localparam int unsigned FIFO_AW = $clog2(DEPTH);
    localparam int unsigned USE_W   = FIFO_AW + 1;

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    if (!nreq_legal(NREQ)) begin : g_bad_nreq
        $error("fifo_rr_arbiter: NREQ must be within 2..16");
    end
    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("fifo_rr_arbiter: DEPTH must be at least 2");
    end
    if (!max_per_req_legal(MAX_PER_REQ, DEPTH)) begin : g_bad_max
        $error("fifo_rr_arbiter: MAX_PER_REQ must be within 1..DEPTH");
    end

    logic [ID_W-1:0]    rr_q, gnt_idx;
    logic [CNT_W-1:0]   cnt_q [NREQ];
    logic [NREQ-1:0]    eligible, gnt;
    logic               gnt_valid, pop, fifo_full, fifo_empty;
    logic [FIFO_AW-1:0] fifo_usage;
    logic [USE_W-1:0]   cnt_sum;
    entry_t             push_entry, head_entry;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++)
            eligible[i] = bus.req_i[i] && (cnt_q[i] < CNT_W'(MAX_PER_REQ))
                          && !fifo_full && !flush_i && !rst_i;
    end

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .eligible (eligible),
        .ptr      (rr_q),
        .gnt      (gnt),
        .valid    (gnt_valid)
    );

    always_comb begin
        gnt_idx    = '0;
        push_entry = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx         = ID_W'(i);
                push_entry.id   = ID_W'(i);
                push_entry.data = bus.data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.gnt_o       = gnt;
    assign bus.out_valid_o = !fifo_empty && !flush_i;
    assign bus.out_data_o  = head_entry.data;
    assign bus.out_id_o    = head_entry.id;
    assign pop             = bus.out_valid_o && bus.out_ready_i;
    assign full_o          = fifo_full;
    // FIFO count wraps to 0 when full, so the full term supplies DEPTH.
    assign usage_o         = fifo_full ? USE_W'(DEPTH) : {1'b0, fifo_usage};

    // Synchronous reset is applied to the FIFO through its flush input.
    fifo_v3_old #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (ID_W + DATA_WIDTH),
        .DEPTH        (DEPTH),
        .dtype        (entry_t)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (1'b1),
        .flush_i    (flush_i || rst_i),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (fifo_usage),
        .data_i     (push_entry),
        .push_i     (gnt_valid),
        .data_o     (head_entry),
        .pop_i      (pop)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rr_q <= '0;
            for (int i = 0; i < NREQ; i++)
                cnt_q[i] <= '0;
        end else begin
            if (gnt_valid)
                rr_q <= (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] && !(pop && head_entry.id == ID_W'(i)))
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                else if (!gnt[i] && pop && head_entry.id == ID_W'(i))
                    cnt_q[i] <= cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        cnt_sum = '0;
        for (int i = 0; i < NREQ; i++)
            cnt_sum = cnt_sum + USE_W'(cnt_q[i]);
    end

    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt));
    a_no_gnt_full: assert property (@(posedge clk_i) disable iff (rst_i) full_o |-> (gnt == '0));
    a_cnt_sum: assert property (@(posedge clk_i) disable iff (rst_i) cnt_sum == usage_o);

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt_chk
        a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q[g] <= CNT_W'(MAX_PER_REQ));
    end
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: round robin, cap, full, flush, wrap, reset.
module tb_fifo_rr_arbiter;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned MAXR  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          full;
    logic [3:0]    usage;
    logic [DW-1:0] din [NREQ];
    int            n_checks = 0;
    int            n_fail = 0;

    fifo_rr_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW)) bus ();
    assign bus.data_i = {din[3], din[2], din[1], din[0]};

    fifo_rr_arbiter #(
        .NREQ(NREQ), .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_PER_REQ(MAXR)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus),
        .full_o  (full),
        .usage_o (usage)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input int id, input logic [DW-1:0] data);
        check_val({tag, "_valid"}, 64'(bus.out_valid_o), 64'd1);
        check_val({tag, "_id"}, 64'(bus.out_id_o), 64'(id));
        check_val({tag, "_data"}, 64'(bus.out_data_o), 64'(data));
    endtask

    initial begin
        bus.req_i = '0;
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < NREQ; i++) din[i] = '0;

        // reset state
        tick();
        rst = 1'b0;
        #1;
        check_val("rst_gnt", 64'(bus.gnt_o), 64'd0);
        check_val("rst_valid", 64'(bus.out_valid_o), 64'd0);
        check_val("rst_full", 64'(full), 64'd0);
        check_val("rst_usage", 64'(usage), 64'd0);

        // round robin: grants 0,1,2,3,0, each output one cycle later
        bus.req_i = 4'b1111;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < NREQ; i++) din[i] = 32'hA0 + i;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_val("rr_gnt", 64'(bus.gnt_o), 64'(1 << (k % 4)));
            if (k == 0) begin
                check_val("rr_first_valid", 64'(bus.out_valid_o), 64'd0);
            end else begin
                check_head("rr_out", (k - 1) % 4, 32'hA0 + ((k - 1) % 4));
                check_val("rr_usage", 64'(usage), 64'd1);
            end
            tick();
        end
        bus.req_i = 4'b0000;
        #1;
        check_head("rr_last", 0, 32'hA0);
        tick();
        check_val("rr_drained_valid", 64'(bus.out_valid_o), 64'd0);
        check_val("rr_drained_usage", 64'(usage), 64'd0);

        // per-requester cap: req 2 alone, no pops
        bus.req_i = 4'b0100;
        bus.out_ready_i = 1'b0;
        din[2] = 32'hC2;
        for (int j = 0; j < 4; j++) begin
            #1;
            check_val("cap_gnt", 64'(bus.gnt_o), 64'b0100);
            check_val("cap_usage", 64'(usage), 64'(j));
            tick();
        end
        for (int j = 0; j < 2; j++) begin
            #1;
            check_val("cap_block_gnt", 64'(bus.gnt_o), 64'd0);
            check_val("cap_block_usage", 64'(usage), 64'd4);
            tick();
        end
        bus.out_ready_i = 1'b1;
        #1;
        check_val("cap_pop_gnt", 64'(bus.gnt_o), 64'd0);
        check_head("cap_pop", 2, 32'hC2);
        tick();
        bus.out_ready_i = 1'b0;
        #1;
        check_val("cap_regrant_usage", 64'(usage), 64'd3);
        check_val("cap_regrant_gnt", 64'(bus.gnt_o), 64'b0100);
        tick();
        check_val("cap_again_gnt", 64'(bus.gnt_o), 64'd0);
        check_val("cap_again_usage", 64'(usage), 64'd4);

        // fill to DEPTH with reqs 0 and 1 (pointer sits at 3)
        bus.req_i = 4'b0011;
        din[0] = 32'hB0;
        din[1] = 32'hB1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check_val("fill_gnt", 64'(bus.gnt_o), 64'((j % 2 == 0) ? 4'b0001 : 4'b0010));
            check_val("fill_usage", 64'(usage), 64'(4 + j));
            tick();
        end
        bus.req_i = 4'b0001;
        bus.out_ready_i = 1'b1;
        #1;
        check_val("full_gnt", 64'(bus.gnt_o), 64'd0);
        check_val("full_flag", 64'(full), 64'd1);
        check_val("full_usage", 64'(usage), 64'd8);
        check_head("full_pop", 2, 32'hC2);
        tick();
        bus.out_ready_i = 1'b0;
        #1;
        check_val("full_after_usage", 64'(usage), 64'd7);
        check_val("full_after_flag", 64'(full), 64'd0);
        check_val("full_after_gnt", 64'(bus.gnt_o), 64'b0001);
        tick();
        check_val("refill_usage", 64'(usage), 64'd8);
        check_val("refill_flag", 64'(full), 64'd1);
        check_val("refill_gnt", 64'(bus.gnt_o), 64'd0);

        // flush with requests and ready asserted
        flush = 1'b1;
        bus.req_i = 4'b1111;
        bus.out_ready_i = 1'b1;
        #1;
        check_val("flush_gnt", 64'(bus.gnt_o), 64'd0);
        check_val("flush_valid", 64'(bus.out_valid_o), 64'd0);
        tick();
        flush = 1'b0;
        bus.out_ready_i = 1'b0;
        din[0] = 32'hD0;
        #1;
        check_val("postflush_usage", 64'(usage), 64'd0);
        check_val("postflush_full", 64'(full), 64'd0);
        check_val("postflush_valid", 64'(bus.out_valid_o), 64'd0);
        check_val("postflush_gnt", 64'(bus.gnt_o), 64'b0001);
        tick();
        bus.req_i = 4'b0001;
        for (int j = 0; j < 3; j++) begin
            #1;
            check_val("postflush_cnt_gnt", 64'(bus.gnt_o), 64'b0001);
            tick();
        end
        #1;
        check_val("postflush_cap_gnt", 64'(bus.gnt_o), 64'd0);
        check_val("postflush_cap_usage", 64'(usage), 64'd4);

        // drain
        bus.req_i = 4'b0000;
        bus.out_ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check_head("drain", 0, 32'hD0);
            tick();
        end
        check_val("drain_valid", 64'(bus.out_valid_o), 64'd0);
        check_val("drain_usage", 64'(usage), 64'd0);

        // pointer wrap: grant 3, then 4'b1001 alternates 0,3
        bus.req_i = 4'b1000;
        din[3] = 32'hE3;
        din[0] = 32'hE0;
        #1;
        check_val("wrap_gnt3", 64'(bus.gnt_o), 64'b1000);
        tick();
        bus.req_i = 4'b1001;
        #1;
        check_val("wrap_gnt0", 64'(bus.gnt_o), 64'b0001);
        check_head("wrap_out3", 3, 32'hE3);
        tick();
        check_val("wrap_gnt3b", 64'(bus.gnt_o), 64'b1000);
        check_head("wrap_out0", 0, 32'hE0);
        tick();
        check_val("wrap_gnt0b", 64'(bus.gnt_o), 64'b0001);
        check_head("wrap_out3b", 3, 32'hE3);
        tick();
        bus.req_i = 4'b0000;
        #1;
        check_head("wrap_out0b", 0, 32'hE0);
        tick();
        check_val("wrap_empty", 64'(bus.out_valid_o), 64'd0);

        // reset mid-stream with three entries held
        bus.req_i = 4'b0111;
        bus.out_ready_i = 1'b0;
        din[0] = 32'hF0;
        din[1] = 32'hF1;
        din[2] = 32'hF2;
        #1;
        check_val("pre_rst_gnt1", 64'(bus.gnt_o), 64'b0010);
        tick();
        check_val("pre_rst_gnt2", 64'(bus.gnt_o), 64'b0100);
        tick();
        check_val("pre_rst_gnt0", 64'(bus.gnt_o), 64'b0001);
        tick();
        check_val("pre_rst_usage", 64'(usage), 64'd3);
        bus.req_i = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_val("mid_rst_valid", 64'(bus.out_valid_o), 64'd0);
        check_val("mid_rst_usage", 64'(usage), 64'd0);
        check_val("mid_rst_full", 64'(full), 64'd0);
        check_val("mid_rst_gnt", 64'(bus.gnt_o), 64'd0);
        bus.req_i = 4'b0100;
        din[2] = 32'h99;
        #1;
        check_val("post_rst_gnt", 64'(bus.gnt_o), 64'b0100);
        tick();
        bus.req_i = 4'b0000;
        #1;
        check_head("post_rst_out", 2, 32'h99);
        check_val("post_rst_usage", 64'(usage), 64'd1);
        bus.out_ready_i = 1'b1;
        tick();
        check_val("post_rst_drained", 64'(bus.out_valid_o), 64'd0);
        check_val("post_rst_usage0", 64'(usage), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
